// File: rtl/store_narrow_rmw_pkg.sv
// store_narrow_rmw_pkg
//   Shared definitions for the narrowing store unit: size codes, FSM state
//   encodings and the alignment check that the load unit also uses.
package store_narrow_rmw_pkg;

    // Access size codes as carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StMerge = 3'd2,
        StWrite = 3'd3,
        StErr   = 3'd4
    } state_e;

    // True for any access that cannot be performed: the illegal size code, a
    // half on an odd byte, or a word off a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size_e'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = |offset;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge
//   Combinational lane inserter: places the low byte/half/word of i_data into
//   the addressed lanes of i_old_word (little-endian, lane 0 = bits 7:0).
// Ports:
//   i_old_word  32  word currently held in memory
//   i_data      32  register value; only the low byte/half/word is used
//   i_size       2  size code (see store_narrow_rmw_pkg::size_e)
//   i_offset     2  byte offset within the word
//   o_merged    32  merged word
//   o_be         4  lanes replaced
module store_lane_merge
    import store_narrow_rmw_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_merged,
    output logic [3:0]  o_be
);

    always_comb begin
        o_merged = i_old_word;
        o_be     = 4'b0000;
        case (size_e'(i_size))
            SZ_BYTE: begin
                o_merged[{i_offset, 3'b000} +: 8] = i_data[7:0];
                o_be = 4'b0001 << i_offset;
            end
            SZ_HALF: begin
                if (i_offset[1]) begin
                    o_merged[31:16] = i_data[15:0];
                    o_be = 4'b1100;
                end else begin
                    o_merged[15:0] = i_data[15:0];
                    o_be = 4'b0011;
                end
            end
            SZ_WORD: begin
                o_merged = i_data;
                o_be     = 4'b1111;
            end
            default: begin
                o_merged = i_old_word;
                o_be     = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw
//   Narrowing store unit. Word stores are written straight to the data memory;
//   byte/half stores read the word, merge the new lanes and write it back.
//   Misaligned or illegal requests complete with a done+err pulse and no access.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_addr/data/size    byte address, register value, size code
//   mem_re/mem_we         single-cycle read / write strobes to the DM
//   mem_addr              DM word address (req_addr[ADDR_W+1:2])
//   mem_wdata/mem_be      full merged word and modified lanes (zero outside write)
//   mem_rdata             DM read data, valid the cycle after mem_re
//   done/err              completion pulse; err marks a rejected request
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err
);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_data;
    size_e             r_size;
    logic [31:0]       r_merged;
    logic [31:0]       w_merged;
    logic [3:0]        w_be;
    logic              w_xfer;
    logic              w_unused_addr;

    // Address bits above the DM range are deliberately ignored.
    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    assign w_xfer = req_valid && (r_state == StIdle);

    store_lane_merge u_merge (
        .i_old_word (mem_rdata),
        .i_data     (r_data),
        .i_size     (r_size),
        .i_offset   (r_addr[1:0]),
        .o_merged   (w_merged),
        .o_be       (w_be)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_data   <= '0;
            r_size   <= SZ_BYTE;
            r_merged <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer) begin
                r_addr   <= req_addr[ADDR_W+1:0];
                r_data   <= req_data;
                r_size   <= size_e'(req_size);
                // A word store writes the raw value; sub-word stores overwrite
                // this with the merged word in MERGE.
                r_merged <= req_data;
            end else if (r_state == StMerge) begin
                r_merged <= w_merged;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = 4'b0000;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        w_state_next = StErr;
                    end else if (req_size == SZ_WORD) begin
                        w_state_next = StWrite;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StRead: begin
                mem_re       = 1'b1;
                mem_addr     = r_addr[ADDR_W+1:2];
                w_state_next = StMerge;
            end
            StMerge: begin
                w_state_next = StWrite;
            end
            StWrite: begin
                mem_we       = 1'b1;
                mem_addr     = r_addr[ADDR_W+1:2];
                mem_wdata    = r_merged;
                mem_be       = w_be;
                done         = 1'b1;
                w_state_next = StIdle;
            end
            StErr: begin
                done         = 1'b1;
                err          = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule
